spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_slave_if.sv | 29 ++
 rtl/sync_ff.sv | 25 ++
 rtl/spi_slave.sv | 125 ++++++++++++
 tb/tb_spi_slave.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width
// and the mode-0 clocking constants common to master and slave.
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT = 8;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_LOAD  = 2'd1;
  localparam spi_state_t ST_SHIFT = 2'd2;

endpackage

// File: rtl/spi_slave_if.sv
// System-side tx/rx handshake bundle of the SPI slave.
// master = the host logic writing tx bytes and reading rx frames.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              frame_abort;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid,
    input  tx_underrun, frame_abort
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid,
    output tx_underrun, frame_abort
  );

endinterface

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with a configurable
// reset level so idle bus values produce no edge on release.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= {DEPTH{RST_VAL}};
    end else begin
      stg <= {stg[DEPTH-2:0], d};
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled on the board clock, with a
// one-deep tx holding register and strobed rx/underrun/abort.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_brd_clk,
  input  logic              i_reset_n,
  input  logic              i_spi_sclk,
  input  logic              i_spi_ss_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_tx_underrun,
  output logic              o_frame_abort
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic sclk_s, ss_s, mosi_s;
  logic sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_fall;

  spi_state_t        state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, hold;
  logic              hold_full;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(i_brd_clk), .rst_n(i_reset_n), .d(i_spi_sclk), .q(sclk_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(i_brd_clk), .rst_n(i_reset_n), .d(i_spi_ss_n), .q(ss_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(i_brd_clk), .rst_n(i_reset_n), .d(i_spi_mosi), .q(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;

  always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_d        <= 1'b0;
      ss_d          <= 1'b1;
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_frame_abort <= 1'b0;
    end else begin
      sclk_d        <= sclk_s;
      ss_d          <= ss_s;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_frame_abort <= 1'b0;
      if (i_tx_valid && !hold_full) begin
        hold      <= i_tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (ss_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hold_full) begin
            tx_sr     <= hold;
            hold_full <= 1'b0;
          end else begin
            tx_sr         <= '0;
            o_tx_underrun <= 1'b1;
          end
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ss_s) begin
            o_frame_abort <= (bit_cnt != '0);
            rx_sr         <= '0;
            bit_cnt       <= '0;
            state         <= ST_IDLE;
          end else begin
            if (sclk_rise) begin
              rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
              if (bit_cnt == LAST) begin
                o_rx_data  <= {rx_sr[DATA_W-2:0], mosi_s};
                o_rx_valid <= 1'b1;
                bit_cnt    <= '0;
                state      <= ST_LOAD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            // bit_cnt==0 marks the trailing fall after the last bit
            if (sclk_fall && bit_cnt != '0) begin
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_miso    = tx_sr[DATA_W-1];
  assign o_spi_miso_oe = (state != ST_IDLE);
  assign o_tx_ready    = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: mode-0 master model at
// brd_clk/8, rx scoreboard queue and per-scenario tasks.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, ss_n, mosi;
  logic miso, miso_oe;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .i_brd_clk    (clk),
    .i_reset_n    (rst_n),
    .i_spi_sclk   (sclk),
    .i_spi_ss_n   (ss_n),
    .i_spi_mosi   (mosi),
    .o_spi_miso   (miso),
    .o_spi_miso_oe(miso_oe),
    .i_tx_data    (bus.tx_data),
    .i_tx_valid   (bus.tx_valid),
    .o_tx_ready   (bus.tx_ready),
    .o_rx_data    (bus.rx_data),
    .o_rx_valid   (bus.rx_valid),
    .o_tx_underrun(bus.tx_underrun),
    .o_frame_abort(bus.frame_abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int under_cnt = 0;
  int abort_cnt = 0;
  int under_pre_last = 0;
  logic [7:0] exp_rx[$];

  // rx scoreboard plus strobe counters
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      n_cmp++;
      if (exp_rx.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: got %02h, required none", bus.rx_data);
      end else begin
        logic [7:0] e;
        e = exp_rx.pop_front();
        if (bus.rx_data !== e) begin
          n_err++;
          $display("FAIL rx_data: got %02h, required %02h", bus.rx_data, e);
        end
      end
    end
    if (bus.tx_underrun === 1'b1) under_cnt++;
    if (bus.frame_abort === 1'b1) abort_cnt++;
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // mode 0: MOSI set while SCLK low, MISO sampled just before rise
  task automatic frame(input logic [7:0] mo, input int nbits,
                       input logic raise, output logic [7:0] mi);
    mi = '0;
    if (ss_n) begin
      @(negedge clk);
      ss_n = 1'b0;
      half();
      half();
    end
    if (nbits == 8) exp_rx.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      half();
      mi[7-i] = miso;
      if (i == nbits - 1) under_pre_last = under_cnt;
      sclk = 1'b1;
      half();
      sclk = 1'b0;
    end
    if (raise) begin
      half();
      ss_n = 1'b1;
      half();
      half();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({miso, miso_oe, bus.tx_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL rst_pins: got %b, required 001",
               {miso, miso_oe, bus.tx_ready});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL rst_rx_data: got %02h, required 00", bus.rx_data);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus.rx_valid, bus.tx_underrun, bus.frame_abort, miso_oe} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_release_strobes: got %b, required 0000",
               {bus.rx_valid, bus.tx_underrun, bus.frame_abort, miso_oe});
    end
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int r0;
    tx_write(8'hA5);
    n_cmp++;
    if (bus.tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_write: got %b, required 0", bus.tx_ready);
    end
    r0 = rxv_cnt;
    frame(8'h3C, 8, 1'b1, mi);
    n_cmp++;
    if (mi !== 8'hA5) begin
      n_err++;
      $display("FAIL basic_miso: got %02h, required a5", mi);
    end
    n_cmp++;
    if (rxv_cnt - r0 !== 1) begin
      n_err++;
      $display("FAIL basic_rxv_count: got %0d, required 1", rxv_cnt - r0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    int u0;
    u0 = under_cnt;
    frame(8'hC7, 8, 1'b1, mi);
    n_cmp++;
    if (under_pre_last - u0 !== 1) begin
      n_err++;
      $display("FAIL underrun_count: got %0d, required 1", under_pre_last - u0);
    end
    n_cmp++;
    if (mi !== 8'h00) begin
      n_err++;
      $display("FAIL underrun_miso: got %02h, required 00", mi);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2;
    int u0, r0;
    tx_write(8'h11);
    u0 = under_cnt;
    r0 = rxv_cnt;
    fork
      frame(8'h81, 8, 1'b0, m1);
      begin
        repeat (20) @(negedge clk);
        tx_write(8'h22);
      end
    join
    frame(8'h7E, 8, 1'b1, m2);
    n_cmp++;
    if ({m1, m2} !== 16'h1122) begin
      n_err++;
      $display("FAIL b2b_miso: got %04h, required 1122", {m1, m2});
    end
    n_cmp++;
    if (rxv_cnt - r0 !== 2) begin
      n_err++;
      $display("FAIL b2b_rxv_count: got %0d, required 2", rxv_cnt - r0);
    end
    n_cmp++;
    if (under_pre_last - u0 !== 0) begin
      n_err++;
      $display("FAIL b2b_underrun: got %0d, required 0", under_pre_last - u0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int a0, r0;
    tx_write(8'h0F);
    a0 = abort_cnt;
    r0 = rxv_cnt;
    frame(8'hFF, 5, 1'b1, mi);
    n_cmp++;
    if (abort_cnt - a0 !== 1 || rxv_cnt - r0 !== 0) begin
      n_err++;
      $display("FAIL abort_strobes: got abort %0d rxv %0d, required 1 0",
               abort_cnt - a0, rxv_cnt - r0);
    end
    n_cmp++;
    if (miso_oe !== 1'b0) begin
      n_err++;
      $display("FAIL abort_oe: got %b, required 0", miso_oe);
    end
    tx_write(8'h96);
    frame(8'h69, 8, 1'b1, mi);
    n_cmp++;
    if (mi !== 8'h96) begin
      n_err++;
      $display("FAIL abort_next_miso: got %02h, required 96", mi);
    end
  endtask

  task automatic test_ignored_write();
    logic [7:0] mi;
    tx_write(8'h5A);
    tx_write(8'hFF);
    n_cmp++;
    if (bus.tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_ready: got %b, required 0", bus.tx_ready);
    end
    frame(8'hE1, 8, 1'b1, mi);
    n_cmp++;
    if (mi !== 8'h5A) begin
      n_err++;
      $display("FAIL ignored_miso: got %02h, required 5a", mi);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    int r0, u0, a0;
    tx_write(8'h3A);
    frame(8'hB2, 3, 1'b0, mi);
    tx_write(8'h44);
    r0 = rxv_cnt; u0 = under_cnt; a0 = abort_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({miso, miso_oe, bus.tx_ready, bus.rx_valid,
         bus.tx_underrun, bus.frame_abort} !== 6'b001000) begin
      n_err++;
      $display("FAIL midrst_pins: got %b, required 001000",
               {miso, miso_oe, bus.tx_ready, bus.rx_valid,
                bus.tx_underrun, bus.frame_abort});
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_rx_data: got %02h, required 00", bus.rx_data);
    end
    sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (rxv_cnt != r0 || under_cnt != u0 || abort_cnt != a0) begin
      n_err++;
      $display("FAIL midrst_strobes: got rxv %0d und %0d abt %0d, required 0 0 0",
               rxv_cnt - r0, under_cnt - u0, abort_cnt - a0);
    end
    tx_write(8'hC3);
    frame(8'h5A, 8, 1'b1, mi);
    n_cmp++;
    if (mi !== 8'hC3) begin
      n_err++;
      $display("FAIL midrst_next_miso: got %02h, required c3", mi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_ignored_write();
    test_reset_midframe();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_rx.size() != 0) begin
      n_err++;
      $display("FAIL rx_missing: got %0d pending, required 0", exp_rx.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
